clint_timer: RTL

// Core-local interrupt source for the machine-mode CSR file. Holds the 64-bit mtime counter,
// the 64-bit mtimecmp comparator and the msip register, each memory-mapped on a simple

---
 rtl/clint_timer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// ----------------------------------------------------------------------------
// clint_timer
// Core-local interrupt source: 64-bit mtime counter, 64-bit mtimecmp and
// msip, memory-mapped on a simple always-ready request/response bus.
//
// Ports
//   clk                  clock, all state updates on rising edge
//   arstn                asynchronous active-low reset
//   i_req_valid          request strobe (no backpressure)
//   i_req_we             1 = write, 0 = read
//   i_req_addr           word address
//                          0 msip, 1 mtimecmp lo, 2 mtimecmp hi,
//                          3 mtime lo, 4 mtime hi (shadow on read)
//   i_req_wdata          write data
//   o_resp_valid         response strobe, one cycle after each request
//   o_resp_rdata         read data (0 for writes and errors)
//   o_resp_err           request hit an unmapped address (5..7)
//   o_timer_int_call     level, mtime >= mtimecmp (MTIP source)
//   o_software_int_call  level, msip[0] (MSIP source)
// ----------------------------------------------------------------------------
module clint_timer #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 3,
    parameter int          PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_timer_int_call,
    output logic                  o_software_int_call
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    localparam logic [ADDR_WIDTH-1:0] A_MSIP   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_LO = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_HI = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_MT_LO  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_MT_HI  = ADDR_WIDTH'(4);

    logic [PW-1:0]         presc_q, presc_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  msip_q, msip_d;
    logic [31:0]           shadow_q, shadow_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  timer_q, timer_d;
    logic                  sw_q, sw_d;

    logic                  tick;
    logic                  wr;
    logic                  rd;
    logic [31:0]           wdata;

    always_comb begin
        wdata = i_req_wdata[31:0];
        wr    = i_req_valid & i_req_we;
        rd    = i_req_valid & ~i_req_we;

        tick    = (presc_q == PS_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);

        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        shadow_d   = shadow_q;

        // A write to either mtime half overrides the tick: the written half
        // takes wdata, the other half keeps its pre-edge value (no carry).
        if (wr) begin
            case (i_req_addr)
                A_MSIP:   msip_d            = wdata[0];
                A_CMP_LO: mtimecmp_d[31:0]  = wdata;
                A_CMP_HI: mtimecmp_d[63:32] = wdata;
                A_MT_LO:  mtime_d           = {mtime_q[63:32], wdata};
                A_MT_HI: begin
                    mtime_d  = {wdata, mtime_q[31:0]};
                    shadow_d = wdata;
                end
                default: ;
            endcase
        end

        // Reading the low half freezes the high half so a two-read sequence
        // sees a coherent 64-bit value even if a carry lands in between.
        if (rd && i_req_addr == A_MT_LO) begin
            shadow_d = mtime_q[63:32];
        end

        rdata_d = '0;
        err_d   = 1'b0;
        if (i_req_valid) begin
            case (i_req_addr)
                A_MSIP:   if (rd) rdata_d = DATA_WIDTH'({31'd0, msip_q});
                A_CMP_LO: if (rd) rdata_d = DATA_WIDTH'(mtimecmp_q[31:0]);
                A_CMP_HI: if (rd) rdata_d = DATA_WIDTH'(mtimecmp_q[63:32]);
                A_MT_LO:  if (rd) rdata_d = DATA_WIDTH'(mtime_q[31:0]);
                A_MT_HI:  if (rd) rdata_d = DATA_WIDTH'(shadow_q);
                default:  err_d = 1'b1;
            endcase
        end

        resp_valid_d = i_req_valid;
        // Compare against the values being loaded this edge so the line
        // tracks the registers with no extra cycle of lag.
        timer_d      = (mtime_d >= mtimecmp_d);
        sw_d         = msip_q;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            presc_q      <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            msip_q       <= 1'b0;
            shadow_q     <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            timer_q      <= 1'b0;
            sw_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            shadow_q     <= shadow_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            sw_q         <= sw_d;
        end
    end

    assign o_resp_valid        = resp_valid_q;
    assign o_resp_rdata        = rdata_q;
    assign o_resp_err          = err_q;
    assign o_timer_int_call    = timer_q;
    assign o_software_int_call = sw_q;

endmodule
